chess_move_queue: RTL and testbench
===================================

Name: chess_move_queue

Overview:
- Sequencing stage directly downstream of the Avalon-MM control/interface register slave in the chess accelerator.
- Consumes the start bit (control[0]) from the register file and issues one request to the move generator.
- Buffers every generated move in a FIFO and reports done, count and error status back to the register file, from which the HPS pops moves one word per read.

Parameters:
- DEPTH, 32, FIFO entries; power of two, minimum 4.
- TIMEOUT_CYCLES, 4096, idle cycles allowed in COLLECT before aborting with an error.
- MOVE_W, 12, move word width {from_row[11:9], from_col[8:6], to_row[5:3], to_col[2:0]}.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level, control[0] from the slave register file
- done  out  1  control[1]: search complete, FIFO holds the results
- err_timeout  out  1  sticky; set when COLLECT times out
- pop  in  1  one-cycle pulse on an HPS read of the move-data register
- move_out  out  MOVE_W  FIFO head entry (show-ahead); 0 when empty
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- move_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- total_moves  out  8  moves accepted in the current search, saturating at 255
- gen_req  out  1  one-cycle pulse that starts the generator
- gen_abort  out  1  one-cycle pulse that cancels the generator
- gen_valid  in  1  gen_move is valid
- gen_move  in  MOVE_W  generated move
- gen_last  in  1  final beat; allowed with gen_valid=0 (no moves, or terminator only)
- gen_ready  out  1  equals !full

Behaviour:
- Reset (async assert, sync release) clears everything:
  - state=IDLE, FIFO emptied.
  - done, err_timeout, gen_req, gen_abort = 0; move_count = 0; total_moves = 0.
  - start_q = 0; timeout counter = 0.
- start_q registers start; rise = start & !start_q; fall = !start & start_q.
- IDLE:
  - done=0.
  - On rise: flush FIFO, clear total_moves, clear err_timeout, go to REQ next cycle.
  - FIFO contents survive in IDLE until the next rise.
- REQ: gen_req=1 for exactly one cycle, reset timeout counter, go to COLLECT.
  - Latency from start rising to gen_req = 2 cycles (start_q, then REQ).
- COLLECT:
  - Push when gen_valid & gen_ready; total_moves increments (saturating).
  - Any accepted beat or gen_last resets the timeout counter; otherwise the counter increments.
  - gen_last (with or without valid) -> DONE. A valid beat flagged gen_last is pushed if accepted; if not accepted (full) the transition waits.
  - Counter reaching TIMEOUT_CYCLES-1 -> DONE with err_timeout=1 and a gen_abort pulse.
  - fall while in COLLECT -> IDLE with a gen_abort pulse and the FIFO flushed. fall takes priority over gen_last and timeout in the same cycle.
- DONE:
  - done=1; on fall -> IDLE (done drops the cycle after fall is detected).
  - rise cannot occur in DONE without an intervening fall.
- FIFO:
  - Push and pop in the same cycle when non-empty and non-full: count unchanged, both succeed.
  - Pop when full and push pending: pop succeeds; push is stalled this cycle because gen_ready=0, then accepted next cycle.
  - Pop when empty: ignored; move_out stays 0; count stays 0.
  - Pointers wrap modulo DEPTH; full when count==DEPTH.
  - pop is honoured in every state.
- gen_ready is combinational from full only. No combinational path from gen_valid to any output.

Decomposition:
- chess_pkg holds:
  - MOVE_W and field offsets FROM_ROW_LSB=9, FROM_COL_LSB=6, TO_ROW_LSB=3, TO_COL_LSB=0.
  - State enum IDLE/REQ/COLLECT/DONE.
  - Control bit indices START_BIT=0, DONE_BIT=1, ERR_BIT=2.
- Sub-module chess_move_fifo: synchronous show-ahead FIFO with flush, push, pop, count, empty and full. The top holds the FSM, edge detection, timeout and total counters.

Test Plan:
- Reset mid-COLLECT with 3 moves buffered -> all outputs 0, count 0, state IDLE immediately on reset_n=0.
- start 0->1; generator returns 0x0D0, 0x0D9, 0x0E2 with gen_last on the third -> gen_req 2 cycles after start; done=1; count=3; pops yield 0x0D0, 0x0D9, 0x0E2, then empty=1 and move_out=0.
- Generator offers 40 moves with DEPTH=32 and no pops -> gen_ready=0 at count 32; after 8 pops all 40 are accepted in order; total_moves=40.
- gen_last with gen_valid=0 and no moves -> done=1, count=0, total_moves=0.
- No generator activity for TIMEOUT_CYCLES -> done=1, err_timeout=1, one gen_abort pulse; next rise clears err_timeout.
- start falls in COLLECT in the same cycle as gen_last -> IDLE, gen_abort pulse, FIFO flushed, done stays 0.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared definitions for the chess accelerator move-queue slice: move word
// layout, sequencer states and control-register bit positions.
package chess_pkg;

  localparam int MOVE_W       = 12;
  localparam int FROM_ROW_LSB = 9;
  localparam int FROM_COL_LSB = 6;
  localparam int TO_ROW_LSB   = 3;
  localparam int TO_COL_LSB   = 0;

  localparam int START_BIT = 0;
  localparam int DONE_BIT  = 1;
  localparam int ERR_BIT   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic logic [MOVE_W-1:0] pack_move(input logic [2:0] from_row,
                                                  input logic [2:0] from_col,
                                                  input logic [2:0] to_row,
                                                  input logic [2:0] to_col);
    logic [MOVE_W-1:0] word;
    word = '0;
    word[FROM_ROW_LSB +: 3] = from_row;
    word[FROM_COL_LSB +: 3] = from_col;
    word[TO_ROW_LSB +: 3]   = to_row;
    word[TO_COL_LSB +: 3]   = to_col;
    return word;
  endfunction

endpackage

// File: rtl/chess_move_fifo.sv
// Show-ahead FIFO for generated moves: the head word is visible on data_o
// whenever the FIFO holds data and reads as zero when it is empty.
module chess_move_fifo
  import chess_pkg::*;
#(
  parameter int WIDTH = MOVE_W,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Flush dominates; a push into a full FIFO or a pop from an empty one is ignored.
  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    do_push = push_i & ~full_o & ~flush_i;
    do_pop  = pop_i & ~empty_o & ~flush_i;
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/chess_move_queue.sv
// Move-queue sequencer: turns a start level into one generator request and
// buffers the returned moves for word-at-a-time readback by the HPS.
module chess_move_queue
  import chess_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MOVE_W         = chess_pkg::MOVE_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       done,
  output logic                       err_timeout,
  input  logic                       pop,
  output logic [MOVE_W-1:0]          move_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] move_count,
  output logic [7:0]                 total_moves,
  output logic                       gen_req,
  output logic                       gen_abort,
  input  logic                       gen_valid,
  input  logic [MOVE_W-1:0]          gen_move,
  input  logic                       gen_last,
  output logic                       gen_ready
);

  localparam int                 TMR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic             start_q;
  logic             done_q;
  logic             err_q;
  logic             req_q;
  logic             abort_q;
  logic [7:0]       total_q;
  logic [7:0]       total_d;
  logic [TMR_W-1:0] timer_q;

  logic             rise;
  logic             fall;
  logic             accept;
  logic             last_taken;
  logic             flush;
  logic             fifo_full;
  logic             fifo_empty;

  // A valid last beat only ends the search once it has actually been stored.
  always_comb begin
    rise       = start & ~start_q;
    fall       = ~start & start_q;
    accept     = (state_q == COLLECT) & gen_valid & ~fifo_full & ~fall;
    last_taken = gen_last & (accept | ~gen_valid);
    flush      = ((state_q == IDLE) & rise)
               | (((state_q == REQ) | (state_q == COLLECT)) & fall);
    total_d    = (total_q == 8'hFF) ? total_q : total_q + 8'd1;
  end

  chess_move_fifo #(
    .WIDTH (MOVE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush),
    .push_i  (accept),
    .data_i  (gen_move),
    .pop_i   (pop),
    .data_o  (move_out),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (move_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      abort_q <= 1'b0;
      total_q <= '0;
      timer_q <= '0;
    end else begin
      start_q <= start;
      req_q   <= 1'b0;
      abort_q <= 1'b0;
      if (accept) begin
        total_q <= total_d;
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (rise) begin
            total_q <= '0;
            err_q   <= 1'b0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (fall) begin
            state_q <= IDLE;
          end else begin
            req_q   <= 1'b1;
            timer_q <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          // Abandoning the search outranks both completion and timeout.
          if (fall) begin
            abort_q <= 1'b1;
            state_q <= IDLE;
          end else if (last_taken) begin
            timer_q <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (accept || gen_last) begin
            timer_q <= '0;
          end else if (timer_q == TMR_LAST) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        DONE: begin
          if (fall) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done        = done_q;
  assign err_timeout = err_q;
  assign gen_req     = req_q;
  assign gen_abort   = abort_q;
  assign total_moves = total_q;
  assign empty       = fifo_empty;
  assign full        = fifo_full;
  assign gen_ready   = ~fifo_full;

endmodule

// File: tb/tb_chess_move_queue.sv
// Bench for chess_move_queue: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_chess_move_queue;

  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 4096;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_COL  = 2;
  localparam int PH_DONE = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        pop;
  logic        gen_valid;
  logic        gen_last;
  logic [11:0] gen_move;
  logic [11:0] move_out;
  logic        done;
  logic        err_timeout;
  logic        empty;
  logic        full;
  logic        gen_req;
  logic        gen_abort;
  logic        gen_ready;
  logic [5:0]  move_count;
  logic [7:0]  total_moves;

  int checkCount = 0;
  int passCount  = 0;
  bit cmpEn      = 1'b0;

  int          mPhase  = PH_IDLE;
  logic        mStartQ = 1'b0;
  bit          mDone   = 1'b0;
  bit          mErr    = 1'b0;
  bit          mReq    = 1'b0;
  bit          mAbort  = 1'b0;
  int          mTotal  = 0;
  int          mIdle   = 0;
  logic [11:0] mq[$];

  chess_move_queue #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT),
    .MOVE_W         (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .done        (done),
    .err_timeout (err_timeout),
    .pop         (pop),
    .move_out    (move_out),
    .empty       (empty),
    .full        (full),
    .move_count  (move_count),
    .total_moves (total_moves),
    .gen_req     (gen_req),
    .gen_abort   (gen_abort),
    .gen_valid   (gen_valid),
    .gen_move    (gen_move),
    .gen_last    (gen_last),
    .gen_ready   (gen_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [11:0] m,
                               input logic l, input logic p);
    start     = s;
    gen_valid = v;
    gen_move  = m;
    gen_last  = l;
    pop       = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mPhase = PH_IDLE; mStartQ = 1'b0; mDone = 0; mErr = 0; mReq = 0; mAbort = 0;
    mTotal = 0; mIdle = 0; mq.delete();
  endtask

  // One clock of the sequencer's rules, applied to the inputs seen at the edge.
  task automatic modelStep();
    bit rise, fall, wasFull, wasEmpty, acc, flushNow;
    rise     = start && !mStartQ;
    fall     = !start && mStartQ;
    wasFull  = (mq.size() == DEPTH);
    wasEmpty = (mq.size() == 0);
    acc      = (mPhase == PH_COL) && gen_valid && !wasFull && !fall;
    flushNow = ((mPhase == PH_IDLE) && rise) || (((mPhase == PH_REQ) || (mPhase == PH_COL)) && fall);
    mReq = 0;
    mAbort = 0;
    if (flushNow) mq.delete();
    else begin
      if (pop && !wasEmpty) void'(mq.pop_front());
      if (acc) mq.push_back(gen_move);
    end
    if (acc && mTotal < 255) mTotal++;
    case (mPhase)
      PH_IDLE: if (rise) begin mTotal = 0; mErr = 0; mPhase = PH_REQ; end
      PH_REQ: begin
        if (fall) mPhase = PH_IDLE;
        else begin mReq = 1; mIdle = 0; mPhase = PH_COL; end
      end
      PH_COL: begin
        if (fall) begin mAbort = 1; mPhase = PH_IDLE; end
        else if (gen_last && (acc || !gen_valid)) begin mDone = 1; mPhase = PH_DONE; end
        else if (acc || gen_last) mIdle = 0;
        else if (mIdle == TIMEOUT - 1) begin mDone = 1; mErr = 1; mAbort = 1; mPhase = PH_DONE; end
        else mIdle++;
      end
      default: if (fall) begin mDone = 0; mPhase = PH_IDLE; end
    endcase
    mStartQ = start;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) modelReset();
      else modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmpEn) begin
        checkOutput("m_done", done, mDone);
        checkOutput("m_err", err_timeout, mErr);
        checkOutput("m_req", gen_req, mReq);
        checkOutput("m_abort", gen_abort, mAbort);
        checkOutput("m_total", total_moves, mTotal);
        checkOutput("m_count", move_count, mq.size());
        checkOutput("m_empty", empty, mq.size() == 0);
        checkOutput("m_full", full, mq.size() == DEPTH);
        checkOutput("m_ready", gen_ready, mq.size() != DEPTH);
        checkOutput("m_head", move_out, (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] expMoves[3];
    int sent, pops, cyc, n, aborts, len, lastDen, abortAt, idleLen;
    bit sawFull, rdy, emp, v, p;

    expMoves[0] = 12'h0D0; expMoves[1] = 12'h0D9; expMoves[2] = 12'h0E2;
    reset_n = 1'b0;
    applyStimulus(0, 0, 12'h000, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    cmpEn = 1'b1;
    tick();
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", move_count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_ready", gen_ready, 1);
    checkOutput("pack_move", chess_pkg::pack_move(3'd0, 3'd3, 3'd2, 3'd0), 12'h0D0);

    // Reset in the middle of a collection with three moves buffered.
    applyStimulus(1, 0, 12'h000, 0, 0); tick(); tick();
    for (int i = 0; i < 3; i++) begin applyStimulus(1, 1, 12'(12'h300 + i), 0, 0); tick(); end
    applyStimulus(1, 0, 12'h000, 0, 0);
    checkOutput("pre_rst_count", move_count, 3);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_count", move_count, 0);
    checkOutput("arst_total", total_moves, 0);
    checkOutput("arst_move", move_out, 0);
    checkOutput("arst_empty", empty, 1);
    checkOutput("arst_flags", {done, err_timeout, gen_req, gen_abort}, 0);
    applyStimulus(0, 0, 12'h000, 0, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Three-move search, request latency and show-ahead readback.
    applyStimulus(1, 0, 12'h000, 0, 0); tick();
    checkOutput("req_lat1", gen_req, 0);
    tick();
    checkOutput("req_lat2", gen_req, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, expMoves[i], i == 2, 0); tick();
    end
    applyStimulus(1, 0, 12'h000, 0, 0);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_count", move_count, 3);
    checkOutput("t2_total", total_moves, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_head", move_out, expMoves[i]);
      applyStimulus(1, 0, 12'h000, 0, 1); tick();
      applyStimulus(1, 0, 12'h000, 0, 0);
    end
    checkOutput("t2_empty", empty, 1);
    checkOutput("t2_move0", move_out, 0);
    applyStimulus(1, 0, 12'h000, 0, 1); tick();
    applyStimulus(0, 0, 12'h000, 0, 0);
    checkOutput("t2_popempty", move_count, 0);
    checkOutput("t2_done_hold", done, 1);
    tick();
    checkOutput("t2_done_drop", done, 0);

    // Forty offered moves against a 32-deep FIFO, with eight pops once it fills.
    applyStimulus(1, 0, 12'h000, 0, 0); tick(); tick();
    sent = 0; pops = 0; cyc = 0; sawFull = 0;
    while ((sent < 40 || pops < 8) && cyc < 400) begin
      v = (sent < 40);
      p = sawFull && (pops < 8);
      applyStimulus(1, v, 12'(12'h100 + sent), sent == 39, p);
      @(negedge clk);
      rdy = gen_ready; emp = empty;
      if (!sawFull && !rdy) begin
        sawFull = 1;
        checkOutput("t3_full_count", move_count, 32);
        checkOutput("t3_full_flag", full, 1);
      end
      if (p) checkOutput("t3_pop_order", move_out, 12'h100 + pops);
      @(posedge clk); #1;
      if (v && rdy) sent++;
      if (p && !emp) pops++;
      cyc++;
    end
    if (cyc >= 400) checkOutput("t3_bound", cyc, 0);
    applyStimulus(1, 0, 12'h000, 0, 0); tick();
    checkOutput("t3_done", done, 1);
    checkOutput("t3_total", total_moves, 40);
    checkOutput("t3_count", move_count, 32);
    for (int i = 8; i < 40; i++) begin
      checkOutput("t3_drain", move_out, 12'h100 + i);
      applyStimulus(1, 0, 12'h000, 0, 1); tick();
    end
    applyStimulus(0, 0, 12'h000, 0, 0); tick();
    checkOutput("t3_empty", empty, 1);

    // Terminator-only search.
    applyStimulus(1, 0, 12'h000, 0, 0); tick(); tick();
    applyStimulus(1, 0, 12'h000, 1, 0); tick();
    applyStimulus(1, 0, 12'h000, 0, 0);
    checkOutput("t4_done", done, 1);
    checkOutput("t4_count", move_count, 0);
    checkOutput("t4_total", total_moves, 0);
    applyStimulus(0, 0, 12'h000, 0, 0); tick(); tick();

    // Silent generator: timeout after exactly TIMEOUT collect cycles.
    applyStimulus(1, 0, 12'h000, 0, 0); tick(); tick();
    checkOutput("t5_req", gen_req, 1);
    n = 0; aborts = 0;
    while (!done && n < 5000) begin
      tick(); n++;
      if (gen_abort) aborts++;
    end
    checkOutput("t5_cycles", n, 4096);
    checkOutput("t5_err", err_timeout, 1);
    tick();
    if (gen_abort) aborts++;
    checkOutput("t5_aborts", aborts, 1);
    applyStimulus(0, 0, 12'h000, 0, 0); tick(); tick();
    checkOutput("t5_sticky", err_timeout, 1);
    applyStimulus(1, 0, 12'h000, 0, 0); tick();
    checkOutput("t5_err_clear", err_timeout, 0);
    tick();
    applyStimulus(1, 0, 12'h000, 1, 0); tick();
    applyStimulus(0, 0, 12'h000, 0, 0); tick(); tick();

    // start falls in the same cycle as the final beat.
    applyStimulus(1, 0, 12'h000, 0, 0); tick(); tick();
    applyStimulus(1, 1, 12'h0A1, 0, 0); tick();
    applyStimulus(1, 1, 12'h0A2, 0, 0); tick();
    checkOutput("t6_pre_count", move_count, 2);
    applyStimulus(0, 1, 12'h0A3, 1, 0); tick();
    applyStimulus(0, 0, 12'h000, 0, 0);
    checkOutput("t6_abort", gen_abort, 1);
    checkOutput("t6_count", move_count, 0);
    checkOutput("t6_done", done, 0);
    tick();
    checkOutput("t6_done_hold", done, 0);

    // Long search with continuous draining: total_moves saturates.
    applyStimulus(1, 0, 12'h000, 0, 0); tick(); tick();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 1, 12'($urandom), 0, 1); tick();
    end
    applyStimulus(1, 0, 12'h000, 0, 0);
    checkOutput("t7_total_sat", total_moves, 255);
    applyStimulus(1, 0, 12'h000, 1, 1); tick();
    applyStimulus(0, 0, 12'h000, 0, 0); tick();

    // Randomized searches against the reference model.
    for (int s = 0; s < 25; s++) begin
      len     = $urandom_range(20, 250);
      lastDen = $urandom_range(8, 80);
      abortAt = ($urandom_range(0, 4) == 0) ? $urandom_range(3, len) : -1;
      applyStimulus(1, 0, 12'h000, 0, 0); tick();
      for (int c = 0; c < len; c++) begin
        if (c == abortAt) break;
        applyStimulus(1, $urandom_range(0, 3) != 0, 12'($urandom),
                      $urandom_range(0, lastDen - 1) == 0, $urandom_range(0, 2) == 0);
        tick();
      end
      idleLen = $urandom_range(1, 6);
      for (int c = 0; c < idleLen; c++) begin
        applyStimulus(0, $urandom_range(0, 1) == 1, 12'($urandom), 0, $urandom_range(0, 1) == 1);
        tick();
      end
    end

    applyStimulus(0, 0, 12'h000, 0, 0); tick();
    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
